// File: rtl/seg_scan_if.sv
// Bus bundle between the seven-segment scan controller and its user.
// master drives value/load/en/dp_in; slave (the controller) drives the display pins.
interface seg_scan_if;
   logic [15:0] value;
   logic        load;
   logic [3:0]  en;
   logic [3:0]  dp_in;
   logic [6:0]  segs;
   logic        dp;
   logic [3:0]  anodes;
   logic        pending;
   logic        frame_tick;

   modport master (
      output value, load, en, dp_in,
      input  segs, dp, anodes, pending, frame_tick
   );

   modport slave (
      input  value, load, en, dp_in,
      output segs, dp, anodes, pending, frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Time-multiplexes a double-buffered 16-bit hex value onto shared cathodes,
// blanking the start of each digit slot to suppress ghosting. New values are
// committed only at a frame boundary so a frame never mixes old and new digits.
// All display pins are registered: they reflect the previous cycle's scan state.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 100
) (
   input logic        clk,
   input logic        rst_n,
   seg_scan_if.slave  bus
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   disp;
   logic [15:0]   shadow;
   logic          pending_q;
   logic [6:0]    segs_q;
   logic          dp_q;
   logic [3:0]    anodes_q;
   logic          frame_tick_q;

   logic          slot_end;
   logic          frame_end;
   logic          in_blank;
   logic          drive;
   logic [3:0]    nib;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0001100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 2'd3);
   assign in_blank  = (cnt < BLANK_END);
   assign drive     = !in_blank && bus.en[idx];

   // Select the nibble of the committed value for the current digit slot.
   always_comb begin
      nib = disp[3:0];
      case (idx)
         2'd0:    nib = disp[3:0];
         2'd1:    nib = disp[7:4];
         2'd2:    nib = disp[11:8];
         default: nib = disp[15:12];
      endcase
   end

   // Slot counter and digit index; the index advances when a slot completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Double buffer: loads land in shadow and commit at a frame end; a load
   // coinciding with the frame end bypasses the shadow so it is not delayed
   // by a whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp      <= 16'h0000;
         shadow    <= 16'h0000;
         pending_q <= 1'b0;
      end else begin
         if (bus.load) begin
            shadow <= bus.value;
         end
         if (frame_end) begin
            pending_q <= 1'b0;
            if (bus.load) begin
               disp <= bus.value;
            end else if (pending_q) begin
               disp <= shadow;
            end
         end else if (bus.load) begin
            pending_q <= 1'b1;
         end
      end
   end

   // Registered display pins; a single one-hot anode register keeps two
   // digits from ever being driven in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anodes_q     <= 4'b1111;
         segs_q       <= 7'b1111111;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= frame_end;
         if (drive) begin
            anodes_q <= ~(4'b0001 << idx);
            segs_q   <= hex_to_seg(nib);
            dp_q     <= ~bus.dp_in[idx];
         end else begin
            anodes_q <= 4'b1111;
            segs_q   <= 7'b1111111;
            dp_q     <= 1'b1;
         end
      end
   end

   assign bus.anodes     = anodes_q;
   assign bus.segs       = segs_q;
   assign bus.dp         = dp_q;
   assign bus.pending    = pending_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the board's four-digit, common-anode seven-segment display. It holds a 16-bit hex value and time-multiplexes its four nibbles onto the shared cathode lines, one digit slot at a time, with a blanking gap between slots to suppress ghosting. New values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits. It contains the hex-to-segment decode internally and drives the display pins directly.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (2 ms frame at 100 MHz); legal range ≥ 2.
- BLANK_CYCLES, 100: blanked cycles at the start of each slot; legal range 0 .. REFRESH_DIV-1.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  16  hex value; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- load  in  1  single-cycle strobe; captures value into the shadow register.
- en  in  4  per-digit enable; en[i]=0 keeps digit i dark for its slot.
- dp_in  in  4  per-digit decimal point, active-high request.
- segs  out  7  cathodes a..g on segs[6]..segs[0], active-low.
- dp  out  1  decimal-point cathode, active-low.
- anodes  out  4  anodes, active-low one-hot; anodes[0] is the rightmost digit.
- pending  out  1  high while a loaded value waits for commit.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1. Digit index idx runs 0..3.
- On the edge where cnt==REFRESH_DIV-1: cnt returns to 0 and idx advances, wrapping 3→0.
- A frame end is cnt==REFRESH_DIV-1 with idx==3.
- Display state per (cnt, idx):
  - BLANK, when cnt < BLANK_CYCLES: anodes=1111, segs=1111111, dp=1.
  - DRIVE, otherwise: if en[idx]=1, anodes is low only at bit idx, segs is the decode of disp nibble idx, and dp=~dp_in[idx]. If en[idx]=0, outputs are the same as BLANK.
- Decode, segs for 0–F:
  - 0000001, 1001111, 0010010, 0000110
  - 1001100, 0100100, 0100000, 0001111
  - 0000000, 0001100, 0001000, 1100000
  - 0110001, 1000010, 0110000, 0111000
- Buffering:
  - load=1 writes value into shadow and sets pending.
  - At a frame-end edge with pending=1: disp←shadow and pending←0.
  - Repeated loads before commit overwrite shadow; the last one wins.
  - If load coincides with a frame-end edge, value is written directly to disp and pending stays 0 at that edge.
- frame_tick=1 for exactly the cycle following each frame-end edge.
- en and dp_in are not buffered. They are sampled each cycle.

## Timing
- Reset (async assert, sync release) sets:
  - cnt=0, idx=0, disp=0, shadow=0, pending=0.
  - anodes=1111, segs=1111111, dp=1, frame_tick=0.
- segs, dp, anodes and frame_tick are registered. Each cycle they reflect the cnt/idx/disp/en/dp_in values of the previous cycle, a 1-cycle latency.
- After rst_n deasserts:
  - The first edge yields BLANK outputs for slot 0, or DRIVE when BLANK_CYCLES=0.
  - Each slot shows BLANK for BLANK_CYCLES cycles, then DRIVE for REFRESH_DIV-BLANK_CYCLES cycles.
  - The frame period is 4·REFRESH_DIV cycles.
- pending rises on the edge after load and falls on the commit edge.
- The new value first appears on segs in digit 0's DRIVE window of the next frame.
- Reset asserted mid-frame forces the outputs blank immediately, independent of clk. It discards shadow and pending.
- Two digits' anodes are never low in the same cycle, including across slot transitions.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset check: hold rst_n=0 → anodes=1111, segs=1111111, dp=1, pending=0. Release, en=1111, no load → every DRIVE window shows segs=0000001. Anodes sequence 1110→1101→1011→0111 with 2 blank cycles per slot, period 32 cycles.
- Load and commit: pulse load with value=16'h1A2F mid-slot 1 → pending=1 until the frame end, then 0, with frame_tick pulsing. The next frame's digits 0..3 show 0111000, 0010010, 0001000, 1001111 respectively.
- Overwrite before commit: load value=16'h1234, then load value=16'hBEEF within the same frame → only BEEF is displayed. The 1234 pattern never appears on any digit.
- Simultaneous load and frame end: load value=16'h8888 on the frame-end cycle → pending stays 0, and every digit of the following frame shows 0000000.
- Enable and decimal point: en=0101, dp_in=0001 → anodes never show 1101 or 0111. dp=0 only during digit 0's DRIVE window.
- Async reset mid-DRIVE with pending=1: assert rst_n=0 between clock edges → outputs go blank before the next edge. After release, pending=0 and digit 0 shows 0000001.
